// File: rtl/wb_port_arbiter_pkg.sv
// Shared definitions for the writeback port arbiter: default widths,
// the hardwired-zero register index and the lock FSM state encoding.
package wb_port_arbiter_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 32;
  localparam int REG_ZERO   = 0;

  typedef enum logic {
    IDLE  = 1'b0,
    LOCK1 = 1'b1
  } arb_state_t;

endpackage

// File: rtl/wb_port_arbiter_rr_pick2.sv
// Two-way round-robin picker: a lone requester always wins; under
// contention the requester that did not win last time is granted.
module rr_pick2
  import wb_port_arbiter_pkg::*;
(
  input  logic req_0,
  input  logic req_1,
  input  logic last_winner,
  output logic gnt_0,
  output logic gnt_1
);

  // Grant selection from the request pair and the previous winner.
  always_comb begin
    gnt_0 = 1'b0;
    gnt_1 = 1'b0;
    if (req_0 && req_1) begin
      gnt_0 = last_winner;
      gnt_1 = ~last_winner;
    end else begin
      gnt_0 = req_0;
      gnt_1 = req_1;
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: shares the register-file write port between the
// single-cycle ALU path (requester 0) and the multi-cycle unit
// (requester 1). Round-robin with a bounded burst lock for requester 1.
// Grants are combinational; the write port itself is fully registered.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int LOCK_MAX = 4
)
(
  input  logic              clk,
  input  logic              reset,
  input  logic              req_0,
  input  logic [ADDR_W-1:0] addr_0,
  input  logic [DATA_W-1:0] data_0,
  output logic              gnt_0,
  input  logic              req_1,
  input  logic              lock_1,
  input  logic [ADDR_W-1:0] addr_1,
  input  logic [DATA_W-1:0] data_1,
  output logic              gnt_1,
  output logic              selecter,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              lock_expired
);

  localparam logic [3:0]        LOCK_MAX_C = 4'(LOCK_MAX);
  localparam logic [ADDR_W-1:0] ZERO_ADDR  = ADDR_W'(REG_ZERO);

  arb_state_t        state_r;
  logic [3:0]        count_r;
  logic              last_winner_r;
  logic              relock_block_r;

  logic              forced_s;
  logic              hold_s;
  logic              pick_last_s;
  logic              pick_gnt_0_s;
  logic              pick_gnt_1_s;
  logic              enter_lock_s;
  logic              xfer_s;
  logic [ADDR_W-1:0] xfer_addr_s;
  logic [DATA_W-1:0] xfer_data_s;

  // A forced release arbitrates as if requester 1 had just won, so a
  // waiting requester 0 gets the port.
  rr_pick2 u_pick (
    .req_0       (req_0),
    .req_1       (req_1),
    .last_winner (pick_last_s),
    .gnt_0       (pick_gnt_0_s),
    .gnt_1       (pick_gnt_1_s)
  );

  // Lock qualification, final grants and the selected transfer payload.
  always_comb begin
    forced_s = 1'b0;
    hold_s   = 1'b0;
    if ((state_r == LOCK1) && lock_1) begin
      if (count_r == LOCK_MAX_C) begin
        forced_s = 1'b1;
      end else begin
        hold_s = 1'b1;
      end
    end else begin
      forced_s = 1'b0;
      hold_s   = 1'b0;
    end

    pick_last_s = forced_s ? 1'b1 : last_winner_r;

    gnt_0 = 1'b0;
    gnt_1 = 1'b0;
    if (reset) begin
      gnt_0 = 1'b0;
      gnt_1 = 1'b0;
    end else if (hold_s) begin
      // Locked: requester 0 is shut out even when requester 1 idles.
      gnt_0 = 1'b0;
      gnt_1 = req_1;
    end else begin
      gnt_0 = pick_gnt_0_s;
      gnt_1 = pick_gnt_1_s;
    end

    // Re-locking straight out of a forced release is not allowed.
    enter_lock_s = gnt_1 && lock_1 && !hold_s && !forced_s && !relock_block_r;

    xfer_s = gnt_0 | gnt_1;
    if (gnt_1) begin
      xfer_addr_s = addr_1;
      xfer_data_s = data_1;
    end else begin
      xfer_addr_s = addr_0;
      xfer_data_s = data_0;
    end
  end

  // Lock FSM, round-robin history and registered write-port outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= IDLE;
      count_r        <= 4'd0;
      last_winner_r  <= 1'b1;
      relock_block_r <= 1'b0;
      selecter       <= 1'b0;
      wr_en          <= 1'b0;
      wr_addr        <= '0;
      wr_data        <= '0;
      lock_expired   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (enter_lock_s) begin
            state_r <= LOCK1;
            count_r <= 4'd1;
          end else begin
            state_r <= IDLE;
            count_r <= 4'd0;
          end
        end
        LOCK1: begin
          if (hold_s) begin
            state_r <= LOCK1;
            count_r <= count_r + 4'd1;
          end else begin
            state_r <= IDLE;
            count_r <= 4'd0;
          end
        end
        default: begin
          state_r <= IDLE;
          count_r <= 4'd0;
        end
      endcase

      if (gnt_0) begin
        last_winner_r <= 1'b0;
      end else if (gnt_1) begin
        last_winner_r <= 1'b1;
      end else begin
        last_winner_r <= last_winner_r;
      end

      // Block clears after requester 0 is served or has nothing pending.
      if (forced_s) begin
        relock_block_r <= 1'b1;
      end else if (relock_block_r && (gnt_0 || !req_0)) begin
        relock_block_r <= 1'b0;
      end else begin
        relock_block_r <= relock_block_r;
      end

      lock_expired <= forced_s;

      if (xfer_s) begin
        selecter <= gnt_1;
        wr_addr  <= xfer_addr_s;
        wr_data  <= xfer_data_s;
        wr_en    <= (xfer_addr_s != ZERO_ADDR);
      end else begin
        wr_en    <= 1'b0;
      end
    end
  end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between two writeback requesters: requester 0 is the single-cycle ALU path, requester 1 is the multi-cycle unit (load/multiply).
- Arbitrates round-robin, with an optional bounded lock for requester 1 bursts.
- Drives the select of the 5-bit destination-address mux and the 32-bit write-data mux.
- Presents registered write-port signals to the register file.

Parameters:
- DATA_W, 32, width of write data.
- ADDR_W, 5, register address width.
- LOCK_MAX, 4, maximum consecutive cycles requester 1 may hold the port under lock (range 1..15).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req_0  input  1  requester 0 write request.
- addr_0  input  ADDR_W  requester 0 destination register.
- data_0  input  DATA_W  requester 0 write data.
- gnt_0  output  1  requester 0 granted this cycle (combinational).
- req_1  input  1  requester 1 write request.
- lock_1  input  1  requester 1 requests port retention for a burst.
- addr_1  input  ADDR_W  requester 1 destination register.
- data_1  input  DATA_W  requester 1 write data.
- gnt_1  output  1  requester 1 granted this cycle (combinational).
- selecter  output  1  registered mux select; 0 = requester 0 path, 1 = requester 1 path.
- wr_en  output  1  registered register-file write enable.
- wr_addr  output  ADDR_W  registered write address.
- wr_data  output  DATA_W  registered write data.
- lock_expired  output  1  registered one-cycle pulse when a lock is force-released.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset). All state changes on the rising edge of clk.
- Reset values:
  - selecter=0, wr_en=0, wr_addr=0, wr_data=0, lock_expired=0.
  - Internal last_winner=1, so requester 0 wins the first contention.
  - State IDLE, lock counter 0.
- Handshake:
  - A requester asserts req_x with addr/data and holds all three stable until it sees gnt_x high in the same cycle.
  - The transfer occurs in the cycle where req_x and gnt_x are both high.
  - gnt_x is never high while req_x is low.
  - At most one grant per cycle.
- Latency: a transfer granted in cycle N appears on selecter/wr_en/wr_addr/wr_data in cycle N+1. There is no combinational path from inputs to the write-port outputs.
- Write suppression: a granted transfer with addr=0 still completes the handshake, but wr_en=0 for it, because register 0 is hardwired. selecter and wr_addr still update.
- No transfer in a cycle: wr_en=0 next cycle; selecter, wr_addr and wr_data hold their previous values.
- FSM states: IDLE, LOCK1.
- IDLE arbitration:
  - Only req_0 -> grant 0.
  - Only req_1 -> grant 1.
  - Both -> grant the requester that is not last_winner.
  - last_winner updates on every grant.
  - If requester 1 is granted with lock_1=1: go to LOCK1 and set counter=1.
- LOCK1:
  - req_1 wins unconditionally while req_1=1 and lock_1=1 and counter<LOCK_MAX; counter increments per grant.
  - Cycles with req_1=0 while lock_1=1 still count, and do not grant 0.
- LOCK1 exits, all returning to IDLE:
  - lock_1=0 -> IDLE that same cycle; arbitrate as IDLE.
  - counter==LOCK_MAX -> forced release. That cycle arbitrates as IDLE with last_winner=1, so a pending req_0 wins. lock_expired pulses next cycle.
  - After a forced release, requester 1 may re-lock only after one grant to requester 0, or after one cycle with req_0 low.
- Simultaneous same-address requests: both are served in grant order. The later write overwrites; there is no merging.
- Reset mid-lock: reset dominates. Return to IDLE, clear outputs, drop the in-flight registered write (wr_en=0).

Decomposition:
- Shared package: ADDR_W/DATA_W defaults, REG_ZERO=0 constant, and the FSM state encoding (IDLE=0, LOCK1=1).
- Sub-module rr_pick2: combinational 2-way round-robin picker (req_0, req_1, last_winner -> gnt_0, gnt_1).
- The lock FSM, counter and output registers stay in the top.

Test Plan:
- Reset then idle: reset held 2 cycles, no requests -> all outputs 0, gnt_0=gnt_1=0 throughout.
- Single request: req_0 with addr=5, data=0xDEADBEEF in cycle N -> gnt_0=1 in cycle N; in cycle N+1 wr_en=1, wr_addr=5, wr_data=0xDEADBEEF, selecter=0.
- Contention: req_0 and req_1 held continuously for 4 cycles, lock_1=0 -> grants alternate 0,1,0,1; selecter alternates 0,1,0,1 one cycle later.
- Zero register: req_1 with addr=0, data=0x1234 -> gnt_1=1; next cycle wr_en=0, selecter=1, wr_addr=0.
- Lock bound: LOCK_MAX=4; req_1=lock_1=1 held and req_0 held -> gnt_1 for 4 cycles, then gnt_0 in cycle 5; lock_expired=1 in cycle 6.
- Reset mid-lock: reset asserted at lock count 2 -> next cycle wr_en=0, selecter=0, FSM in IDLE. After release, contention grants requester 0 first.
